// File: rtl/array_offset_sat_pipe.sv
// Two-stage valid/ready pipeline: adds or subtracts one offset to every array element
// (optionally saturating), then registers the result with its minimum element and index.
module array_offset_sat_pipe #(
    parameter int DATA_W = 8,
    parameter int ARR_L  = 4,
    parameter int SAT    = 1,
    parameter int IDX_W  = (ARR_L > 1) ? $clog2(ARR_L) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W*ARR_L-1:0]   in_arr,
    input  logic [DATA_W-1:0]         in_value,
    input  logic                      in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W*ARR_L-1:0]   out_arr,
    output logic [DATA_W-1:0]         out_min,
    output logic [IDX_W-1:0]          out_min_idx
);

    logic                     s1_v;
    logic [DATA_W*ARR_L-1:0]  s1_arr;
    logic [DATA_W*ARR_L-1:0]  s1_next;
    logic                     s1_en;
    logic                     s2_en;
    logic [DATA_W-1:0]        min_val;
    logic [IDX_W-1:0]         min_idx;

    // Each stage advances when it is empty or the stage after it is moving.
    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_v || s2_en;
    assign in_ready = s1_en;

    for (genvar g = 0; g < ARR_L; g++) begin : g_elem
        logic [DATA_W-1:0] a;
        logic [DATA_W:0]   sum;
        logic [DATA_W:0]   diff;
        logic [DATA_W-1:0] r;

        assign a    = in_arr[g*DATA_W +: DATA_W];
        assign sum  = {1'b0, a} + {1'b0, in_value};
        // The extra top bit of the difference is the borrow, i.e. a < in_value.
        assign diff = {1'b0, a} - {1'b0, in_value};

        always_comb begin
            r = '0;
            if (in_op) begin
                if ((SAT != 0) && sum[DATA_W]) r = '1;
                else                           r = sum[DATA_W-1:0];
            end else begin
                if ((SAT != 0) && diff[DATA_W]) r = '0;
                else                            r = diff[DATA_W-1:0];
            end
        end

        assign s1_next[g*DATA_W +: DATA_W] = r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_arr <= '0;
        end else if (s1_en) begin
            s1_v   <= in_valid;
            s1_arr <= s1_next;
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_val = s1_arr[DATA_W-1:0];
        min_idx = '0;
        for (int i = 1; i < ARR_L; i++) begin
            if (s1_arr[i*DATA_W +: DATA_W] < min_val) begin
                min_val = s1_arr[i*DATA_W +: DATA_W];
                min_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_arr     <= '0;
            out_min     <= '0;
            out_min_idx <= '0;
        end else if (s2_en) begin
            out_valid   <= s1_v;
            out_arr     <= s1_arr;
            out_min     <= min_val;
            out_min_idx <= min_idx;
        end
    end

endmodule
